// File: rtl/suspi_cmd_rx.sv
// SUSPI upstream command receiver: 11-bit odd-parity frames oversampled 4x on the
// 4 MHz strobe, packet parser (marker/flag/len/payload/CRC) with abort and timeout handling.

module crc16 (
    input  logic [15:0] crc_in,
    input  logic [7:0]  data_in,
    output logic [15:0] crc_out
);
    // CRC-16/CCITT, poly 0x1021, MSB first; the caller supplies the FFFF seed.
    always_comb begin
        crc_out = crc_in ^ {data_in, 8'h00};
        for (int i = 0; i < 8; i++) begin
            crc_out = crc_out[15] ? ({crc_out[14:0], 1'b0} ^ 16'h1021)
                                  : {crc_out[14:0], 1'b0};
        end
    end
endmodule

module suspi_cmd_rx #(
    parameter logic [7:0] MARKER     = 8'hA5,
    parameter int         MAX_LEN    = 2048,
    parameter int         TIMEOUT_BT = 32
) (
    input  logic        bb_clk_in,
    input  logic        rst_n,
    input  logic        strobe_4mhz,
    input  logic        com_in,
    output logic        cmd_valid,
    output logic [7:0]  cmd_flag,
    output logic [15:0] cmd_len,
    output logic        pl_valid,
    output logic [7:0]  pl_data,
    output logic        pl_last,
    output logic        busy,
    output logic        err_parity,
    output logic        err_frame,
    output logic        err_crc,
    output logic        err_hdr,
    output logic        err_timeout
);
    localparam int          TO_LIMIT  = 4 * TIMEOUT_BT;
    localparam int          TO_W      = $clog2(TO_LIMIT + 2);
    localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);
    localparam logic [TO_W-1:0] TO_LIMIT_W = TO_W'(TO_LIMIT);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS} rx_state_t;
    typedef enum logic [2:0] {
        P_MARK, P_FLAG, P_LENH, P_LENL, P_DATA, P_CRCH, P_CRCL
    } pkt_state_t;

    // ---------------- line synchroniser ----------------
    logic [1:0] sync_q;
    logic       line;

    always_ff @(posedge bb_clk_in or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b11;
        else        sync_q <= {sync_q[0], com_in};
    end
    assign line = sync_q[1];

    // ---------------- bit receiver ----------------
    rx_state_t  rx_state_q, rx_state_d;
    logic [1:0] phase_q, phase_d;
    logic [3:0] bit_idx_q, bit_idx_d;
    logic [7:0] shreg_q, shreg_d;
    logic       par_q, par_d;
    logic       byte_stb, stop_ok, par_ok, glitch, start_seen;

    always_ff @(posedge bb_clk_in or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q <= RX_IDLE;
            phase_q    <= 2'd0;
            bit_idx_q  <= 4'd0;
            shreg_q    <= 8'h00;
            par_q      <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            phase_q    <= phase_d;
            bit_idx_q  <= bit_idx_d;
            shreg_q    <= shreg_d;
            par_q      <= par_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        phase_d    = phase_q;
        bit_idx_d  = bit_idx_q;
        shreg_d    = shreg_q;
        par_d      = par_q;
        byte_stb   = 1'b0;
        glitch     = 1'b0;
        start_seen = 1'b0;
        stop_ok    = line;
        par_ok     = ^{shreg_q, par_q};
        case (rx_state_q)
            RX_IDLE: begin
                if (strobe_4mhz && !line) begin
                    rx_state_d = RX_START;
                    phase_d    = 2'd0;
                    start_seen = 1'b1;
                end
            end
            RX_START: begin
                if (strobe_4mhz) begin
                    // Second strobe after the edge is the middle of the start bit.
                    if (phase_q == 2'd1) begin
                        if (line) begin
                            glitch     = 1'b1;
                            rx_state_d = RX_IDLE;
                        end else begin
                            rx_state_d = RX_BITS;
                            phase_d    = 2'd0;
                            bit_idx_d  = 4'd0;
                        end
                    end else begin
                        phase_d = phase_q + 2'd1;
                    end
                end
            end
            RX_BITS: begin
                if (strobe_4mhz) begin
                    phase_d = phase_q + 2'd1;
                    if (phase_q == 2'd3) begin
                        if (bit_idx_q < 4'd8) begin
                            shreg_d   = {line, shreg_q[7:1]};
                            bit_idx_d = bit_idx_q + 4'd1;
                        end else if (bit_idx_q == 4'd8) begin
                            par_d     = line;
                            bit_idx_d = bit_idx_q + 4'd1;
                        end else begin
                            byte_stb   = 1'b1;
                            rx_state_d = RX_IDLE;
                        end
                    end
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // ---------------- packet parser ----------------
    pkt_state_t       pkt_state_q, pkt_state_d;
    logic [7:0]       flag_q, flag_d;
    logic [15:0]      len_q, len_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [15:0]      crc_q, crc_d;
    logic [7:0]       crch_q, crch_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [15:0]      crc_seed, crc_fold, len_new;
    logic             to_fire, last_byte;

    logic        cmd_valid_q, cmd_valid_d;
    logic [7:0]  cmd_flag_q, cmd_flag_d;
    logic [15:0] cmd_len_q, cmd_len_d;
    logic        pl_valid_q, pl_valid_d;
    logic [7:0]  pl_data_q, pl_data_d;
    logic        pl_last_q, pl_last_d;
    logic        busy_q, busy_d;
    logic        err_parity_q, err_parity_d;
    logic        err_frame_q, err_frame_d;
    logic        err_crc_q, err_crc_d;
    logic        err_hdr_q, err_hdr_d;
    logic        err_timeout_q, err_timeout_d;

    // A marker always restarts the CRC from the seed.
    assign crc_seed = (pkt_state_q == P_MARK) ? 16'hFFFF : crc_q;

    crc16 u_crc16 (
        .crc_in  (crc_seed),
        .data_in (shreg_q),
        .crc_out (crc_fold)
    );

    assign len_new   = {len_q[15:8], shreg_q};
    assign last_byte = (cnt_q == len_q - 16'd1);
    assign to_fire   = busy_q && (rx_state_q == RX_IDLE) && strobe_4mhz && line
                       && (to_cnt_q == TO_LIMIT_W);

    always_ff @(posedge bb_clk_in or negedge rst_n) begin
        if (!rst_n) begin
            pkt_state_q   <= P_MARK;
            flag_q        <= 8'h00;
            len_q         <= 16'h0000;
            cnt_q         <= 16'h0000;
            crc_q         <= 16'hFFFF;
            crch_q        <= 8'h00;
            to_cnt_q      <= '0;
            cmd_valid_q   <= 1'b0;
            cmd_flag_q    <= 8'h00;
            cmd_len_q     <= 16'h0000;
            pl_valid_q    <= 1'b0;
            pl_data_q     <= 8'h00;
            pl_last_q     <= 1'b0;
            busy_q        <= 1'b0;
            err_parity_q  <= 1'b0;
            err_frame_q   <= 1'b0;
            err_crc_q     <= 1'b0;
            err_hdr_q     <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            pkt_state_q   <= pkt_state_d;
            flag_q        <= flag_d;
            len_q         <= len_d;
            cnt_q         <= cnt_d;
            crc_q         <= crc_d;
            crch_q        <= crch_d;
            to_cnt_q      <= to_cnt_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_flag_q    <= cmd_flag_d;
            cmd_len_q     <= cmd_len_d;
            pl_valid_q    <= pl_valid_d;
            pl_data_q     <= pl_data_d;
            pl_last_q     <= pl_last_d;
            busy_q        <= busy_d;
            err_parity_q  <= err_parity_d;
            err_frame_q   <= err_frame_d;
            err_crc_q     <= err_crc_d;
            err_hdr_q     <= err_hdr_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    always_comb begin
        pkt_state_d   = pkt_state_q;
        flag_d        = flag_q;
        len_d         = len_q;
        cnt_d         = cnt_q;
        crc_d         = crc_q;
        crch_d        = crch_q;
        cmd_flag_d    = cmd_flag_q;
        cmd_len_d     = cmd_len_q;
        pl_data_d     = pl_data_q;
        busy_d        = busy_q;
        cmd_valid_d   = 1'b0;
        pl_valid_d    = 1'b0;
        pl_last_d     = 1'b0;
        err_parity_d  = 1'b0;
        err_frame_d   = 1'b0;
        err_crc_d     = 1'b0;
        err_hdr_d     = 1'b0;
        err_timeout_d = 1'b0;

        if (!busy_q || start_seen)
            to_cnt_d = '0;
        else if (rx_state_q == RX_IDLE && strobe_4mhz)
            to_cnt_d = to_cnt_q + 1'b1;
        else
            to_cnt_d = to_cnt_q;

        // Line errors take precedence; each one drops the packet back to the marker hunt.
        if (glitch || (byte_stb && !stop_ok)) begin
            err_frame_d = 1'b1;
            pkt_state_d = P_MARK;
            busy_d      = 1'b0;
        end else if (byte_stb && !par_ok) begin
            err_parity_d = 1'b1;
            pkt_state_d  = P_MARK;
            busy_d       = 1'b0;
        end else if (to_fire) begin
            err_timeout_d = 1'b1;
            pkt_state_d   = P_MARK;
            busy_d        = 1'b0;
        end else if (byte_stb) begin
            case (pkt_state_q)
                P_MARK: begin
                    if (shreg_q == MARKER) begin
                        crc_d       = crc_fold;
                        busy_d      = 1'b1;
                        pkt_state_d = P_FLAG;
                    end else begin
                        err_hdr_d = 1'b1;
                    end
                end
                P_FLAG: begin
                    flag_d      = shreg_q;
                    crc_d       = crc_fold;
                    pkt_state_d = P_LENH;
                end
                P_LENH: begin
                    len_d       = {shreg_q, len_q[7:0]};
                    crc_d       = crc_fold;
                    pkt_state_d = P_LENL;
                end
                P_LENL: begin
                    len_d = len_new;
                    crc_d = crc_fold;
                    cnt_d = 16'h0000;
                    if (len_new > MAX_LEN_W) begin
                        err_hdr_d   = 1'b1;
                        pkt_state_d = P_MARK;
                        busy_d      = 1'b0;
                    end else if (len_new == 16'h0000) begin
                        pkt_state_d = P_CRCH;
                    end else begin
                        pkt_state_d = P_DATA;
                    end
                end
                P_DATA: begin
                    crc_d      = crc_fold;
                    pl_valid_d = 1'b1;
                    pl_data_d  = shreg_q;
                    pl_last_d  = last_byte;
                    cnt_d      = cnt_q + 16'd1;
                    if (last_byte) pkt_state_d = P_CRCH;
                end
                P_CRCH: begin
                    crch_d      = shreg_q;
                    pkt_state_d = P_CRCL;
                end
                P_CRCL: begin
                    if ({crch_q, shreg_q} == crc_q) begin
                        cmd_valid_d = 1'b1;
                        cmd_flag_d  = flag_q;
                        cmd_len_d   = len_q;
                    end else begin
                        err_crc_d = 1'b1;
                    end
                    busy_d      = 1'b0;
                    pkt_state_d = P_MARK;
                end
                default: begin
                    pkt_state_d = P_MARK;
                    busy_d      = 1'b0;
                end
            endcase
        end
    end

    assign cmd_valid   = cmd_valid_q;
    assign cmd_flag    = cmd_flag_q;
    assign cmd_len     = cmd_len_q;
    assign pl_valid    = pl_valid_q;
    assign pl_data     = pl_data_q;
    assign pl_last     = pl_last_q;
    assign busy        = busy_q;
    assign err_parity  = err_parity_q;
    assign err_frame   = err_frame_q;
    assign err_crc     = err_crc_q;
    assign err_hdr     = err_hdr_q;
    assign err_timeout = err_timeout_q;
endmodule

// File: tb/tb_suspi_cmd_rx.sv
// Bench for suspi_cmd_rx: directed scenarios plus random packets, checked against a
// byte-level packet model with a bit-serial CRC-16/CCITT reference.
`timescale 1ns/1ps
module tb_suspi_cmd_rx;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        strobe_4mhz = 1'b0;
    logic        com_in = 1'b1;
    logic        cmd_valid, pl_valid, pl_last, busy;
    logic [7:0]  cmd_flag, pl_data;
    logic [15:0] cmd_len;
    logic        err_parity, err_frame, err_crc, err_hdr, err_timeout;

    int tests_run = 0;
    int tests_failed = 0;

    always #42 clk = ~clk;

    int div = 0;
    always @(negedge clk) begin
        strobe_4mhz = (div == 0);
        div = (div == 2) ? 0 : div + 1;
    end

    suspi_cmd_rx dut (
        .bb_clk_in   (clk),
        .rst_n       (rst_n),
        .strobe_4mhz (strobe_4mhz),
        .com_in      (com_in),
        .cmd_valid   (cmd_valid),
        .cmd_flag    (cmd_flag),
        .cmd_len     (cmd_len),
        .pl_valid    (pl_valid),
        .pl_data     (pl_data),
        .pl_last     (pl_last),
        .busy        (busy),
        .err_parity  (err_parity),
        .err_frame   (err_frame),
        .err_crc     (err_crc),
        .err_hdr     (err_hdr),
        .err_timeout (err_timeout)
    );

    // Observed activity since the last clear_mon.
    int n_cmd, n_last, n_par, n_frame, n_crc, n_hdr, n_to, n_coinc, last_idx;
    logic [7:0]  got_flag;
    logic [15:0] got_len;
    logic [7:0]  pl_q[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (cmd_valid) begin
                n_cmd++;
                got_flag = cmd_flag;
                got_len  = cmd_len;
                if (err_parity | err_frame | err_crc | err_hdr | err_timeout) n_coinc++;
            end
            if (pl_valid) begin
                pl_q.push_back(pl_data);
                if (pl_last) begin
                    n_last++;
                    last_idx = pl_q.size() - 1;
                end
            end
            n_par   += int'(err_parity);
            n_frame += int'(err_frame);
            n_crc   += int'(err_crc);
            n_hdr   += int'(err_hdr);
            n_to    += int'(err_timeout);
        end
    end

    // Expected packet model.
    logic [7:0]  pkt_q[$];
    logic [7:0]  exp_pl[$];
    logic [7:0]  exp_flag;
    logic [15:0] exp_len;

    function automatic logic [15:0] crc_model(input int n);
        logic [15:0] c;
        logic fb;
        c = 16'hFFFF;
        for (int k = 0; k < n; k++)
            for (int i = 7; i >= 0; i--) begin
                fb = c[15] ^ pkt_q[k][i];
                c  = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h1021;
            end
        return c;
    endfunction

    task automatic build(input logic [7:0] flag);
        logic [15:0] c;
        exp_flag = flag;
        exp_len  = 16'(exp_pl.size());
        pkt_q.delete();
        pkt_q.push_back(8'hA5);
        pkt_q.push_back(flag);
        pkt_q.push_back(exp_len[15:8]);
        pkt_q.push_back(exp_len[7:0]);
        foreach (exp_pl[i]) pkt_q.push_back(exp_pl[i]);
        c = crc_model(pkt_q.size());
        pkt_q.push_back(c[15:8]);
        pkt_q.push_back(c[7:0]);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        n_cmd = 0; n_last = 0; n_par = 0; n_frame = 0; n_crc = 0;
        n_hdr = 0; n_to = 0; n_coinc = 0; last_idx = -1;
        pl_q.delete();
    endtask

    task automatic idle_bits(input int n);
        com_in = 1'b1;
        repeat (n * 12) @(negedge clk);
    endtask

    // Drives the first nbits of the 11-bit frame (start, d0..d7, parity, stop).
    task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                             input int nbits);
        logic [10:0] fr;
        fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            com_in = fr[i];
            repeat (12) @(negedge clk);
        end
        com_in = 1'b1;
    endtask

    task automatic send_pkt(input string tag);
        $display("[TB] %s: flag=%02h len=%0d crc=%02h%02h", tag, exp_flag, exp_len,
                 pkt_q[pkt_q.size()-2], pkt_q[pkt_q.size()-1]);
        foreach (pkt_q[i]) begin
            send_byte(pkt_q[i], 1'b0, 1'b0, 11);
            idle_bits($urandom_range(0, 2));
        end
        idle_bits(4);
    endtask

    task automatic check_result(input string tag, input bit good);
        check({tag, "_cmd"}, 64'(n_cmd), 64'(good));
        check({tag, "_errcrc"}, 64'(n_crc), 64'(!good));
        check({tag, "_othererr"}, 64'(n_par + n_frame + n_hdr + n_to), 64'd0);
        check({tag, "_coinc"}, 64'(n_coinc), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_plcount"}, 64'(pl_q.size()), 64'(exp_pl.size()));
        check({tag, "_plast"}, 64'(n_last), 64'(exp_pl.size() > 0));
        if (exp_pl.size() > 0) check({tag, "_plast_idx"}, 64'(last_idx), 64'(exp_pl.size() - 1));
        foreach (exp_pl[i])
            if (i < pl_q.size()) check({tag, "_pldata"}, 64'(pl_q[i]), 64'(exp_pl[i]));
        if (good) begin
            check({tag, "_flag"}, 64'(got_flag), 64'(exp_flag));
            check({tag, "_len"}, 64'(got_len), 64'(exp_len));
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({cmd_valid, cmd_flag, cmd_len, pl_valid, pl_data, pl_last, busy,
                    err_parity, err_frame, err_crc, err_hdr, err_timeout});
    endfunction

    initial begin
        clear_mon();
        // Reset state
        repeat (4) @(negedge clk);
        check("reset_outputs", all_outs(), 64'd0);
        rst_n = 1'b1;
        idle_bits(2);

        // 1: zero-length command
        clear_mon(); exp_pl.delete(); build(8'h03); send_pkt("t1");
        check_result("t1", 1'b1);

        // 2: three-byte payload
        clear_mon(); exp_pl = '{8'h11, 8'h22, 8'h33}; build(8'h04); send_pkt("t2");
        check_result("t2", 1'b1);

        // 3: CRC corruption, held outputs, recovery
        clear_mon(); exp_pl.delete(); build(8'h03);
        pkt_q[pkt_q.size()-1] = pkt_q[pkt_q.size()-1] ^ 8'h01;
        send_pkt("t3_bad");
        check_result("t3_bad", 1'b0);
        check("t3_held_flag", 64'(cmd_flag), 64'h04);
        check("t3_held_len", 64'(cmd_len), 64'd3);
        clear_mon(); build(8'h03); send_pkt("t3_good");
        check_result("t3_good", 1'b1);

        // 4: parity error on flag, bad marker, recovery
        clear_mon();
        $display("[TB] t4: marker then flag with bad parity");
        send_byte(8'hA5, 1'b0, 1'b0, 11);
        send_byte(8'h03, 1'b1, 1'b0, 11);
        idle_bits(4);
        check("t4_errpar", 64'(n_par), 64'd1);
        check("t4_par_busy", 64'(busy), 64'd0);
        check("t4_par_other", 64'(n_cmd + n_hdr + n_frame + n_crc + n_to), 64'd0);
        clear_mon();
        $display("[TB] t4: stray byte 5A");
        send_byte(8'h5A, 1'b0, 1'b0, 11);
        idle_bits(4);
        check("t4_errhdr", 64'(n_hdr), 64'd1);
        check("t4_hdr_busy", 64'(busy), 64'd0);
        clear_mon(); exp_pl = '{8'hC3}; build(8'h7E); send_pkt("t4_good");
        check_result("t4_good", 1'b1);

        // 5: timeout after LENH, then idle-line glitch
        clear_mon();
        $display("[TB] t5: A5 03 00 then silence");
        send_byte(8'hA5, 1'b0, 1'b0, 11);
        send_byte(8'h03, 1'b0, 1'b0, 11);
        send_byte(8'h00, 1'b0, 1'b0, 11);
        idle_bits(1);
        check("t5_busy_before", 64'(busy), 64'd1);
        idle_bits(40);
        check("t5_errto", 64'(n_to), 64'd1);
        check("t5_to_busy", 64'(busy), 64'd0);
        check("t5_to_other", 64'(n_cmd + n_hdr + n_frame + n_crc + n_par), 64'd0);
        clear_mon();
        $display("[TB] t5: 0.3-bit glitch");
        com_in = 1'b0;
        repeat (4) @(negedge clk);
        idle_bits(4);
        check("t5_errframe", 64'(n_frame), 64'd1);
        check("t5_glitch_other", 64'(n_cmd + pl_q.size() + n_hdr + n_crc + n_par + n_to), 64'd0);

        // Length boundary: MAX_LEN+1 rejected, MAX_LEN accepted (then times out)
        clear_mon();
        $display("[TB] len: A5 01 08 01");
        send_byte(8'hA5, 1'b0, 1'b0, 11);
        send_byte(8'h01, 1'b0, 1'b0, 11);
        send_byte(8'h08, 1'b0, 1'b0, 11);
        send_byte(8'h01, 1'b0, 1'b0, 11);
        idle_bits(2);
        check("len2049_errhdr", 64'(n_hdr), 64'd1);
        check("len2049_busy", 64'(busy), 64'd0);
        clear_mon();
        $display("[TB] len: A5 01 08 00");
        send_byte(8'hA5, 1'b0, 1'b0, 11);
        send_byte(8'h01, 1'b0, 1'b0, 11);
        send_byte(8'h08, 1'b0, 1'b0, 11);
        send_byte(8'h00, 1'b0, 1'b0, 11);
        idle_bits(2);
        check("len2048_errhdr", 64'(n_hdr), 64'd0);
        check("len2048_busy", 64'(busy), 64'd1);
        idle_bits(40);
        check("len2048_errto", 64'(n_to), 64'd1);

        // 6: reset during payload byte 2
        clear_mon(); exp_pl = '{8'h11, 8'h22, 8'h33}; build(8'h04);
        $display("[TB] t6: reset inside payload byte 2");
        for (int i = 0; i < 5; i++) send_byte(pkt_q[i], 1'b0, 1'b0, 11);
        send_byte(pkt_q[5], 1'b0, 1'b0, 4);
        com_in = 1'b0;
        #20 rst_n = 1'b0;
        #10 check("t6_async_reset", all_outs(), 64'd0);
        repeat (3) @(negedge clk);
        check("t6_reset_hold", all_outs(), 64'd0);
        com_in = 1'b1;
        rst_n  = 1'b1;
        idle_bits(4);
        check("t6_no_cmd", 64'(n_cmd), 64'd0);
        check("t6_after_outs", all_outs(), 64'd0);
        clear_mon(); exp_pl.delete(); build(8'h03); send_pkt("t6_good");
        check_result("t6_good", 1'b1);

        // Random packets, some with a corrupted CRC byte
        for (int r = 0; r < 8; r++) begin
            bit bad;
            clear_mon();
            exp_pl.delete();
            for (int k = 0; k < int'($urandom_range(0, 6)); k++) exp_pl.push_back(8'($urandom));
            build(8'($urandom));
            bad = ($urandom_range(0, 2) == 0);
            if (bad) begin
                int idx;
                idx = pkt_q.size() - 1 - int'($urandom_range(0, 1));
                pkt_q[idx] = pkt_q[idx] ^ (8'h01 << $urandom_range(0, 7));
            end
            send_pkt($sformatf("rnd%0d", r));
            check_result($sformatf("rnd%0d", r), !bad);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
